// File: rtl/aes_encrypt_iter_ctrl.sv
//==============================================================================
// Module  : aes_encrypt_iter_ctrl
// Brief   : Iterative AES-128 encryption controller around a one-round datapath.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module aes_encrypt_iter_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  output logic         ready,
  output logic         busy,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic [127:0] round_in,
  output logic         round_is_last,
  input  logic [127:0] round_out,
  output logic [127:0] ciphertext,
  output logic         done
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    RUN  = 2'b10
  } fsm_t;

  fsm_t         fsm, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [127:0] ct_next;
  logic [3:0]   rnd, rnd_next;
  logic         done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      state_reg  <= '0;
      rnd        <= '0;
      ciphertext <= '0;
      done       <= 1'b0;
    end else begin
      fsm        <= fsm_next;
      state_reg  <= state_next;
      rnd        <= rnd_next;
      ciphertext <= ct_next;
      done       <= done_next;
    end
  end

  always_comb begin
    fsm_next      = fsm;
    state_next    = state_reg;
    rnd_next      = rnd;
    ct_next       = ciphertext;
    done_next     = 1'b0;
    ready         = 1'b0;
    busy          = 1'b0;
    key_idx       = 4'd0;
    round_is_last = 1'b0;
    round_in      = state_reg;

    case (fsm)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          // Initial AddRoundKey uses key 0, which is what key_idx requests here.
          state_next = plaintext ^ round_key;
          rnd_next   = 4'd1;
          fsm_next   = RUN;
        end
      end
      RUN: begin
        busy          = 1'b1;
        key_idx       = rnd;
        round_is_last = (rnd == LAST_RND);
        if (rnd == LAST_RND) begin
          ct_next    = round_out;
          done_next  = 1'b1;
          state_next = round_out;
          rnd_next   = 4'd0;
          fsm_next   = IDLE;
        end else if (rnd < LAST_RND) begin
          state_next = round_out;
          rnd_next   = rnd + 4'd1;
        end else begin
          // A round counter past the last round can only come from corruption.
          rnd_next = 4'd0;
          fsm_next = IDLE;
        end
      end
      default: begin
        rnd_next = 4'd0;
        fsm_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_encrypt_iter_ctrl.sv
//==============================================================================
// Module  : tb_aes_encrypt_iter_ctrl
// Brief   : Directed bench with an AES round/key-store model around the controller.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aes_encrypt_iter_ctrl;

  localparam int NR = 10;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] plaintext;
  logic         ready;
  logic         busy;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic [127:0] round_in;
  logic         round_is_last;
  logic [127:0] round_out;
  logic [127:0] ciphertext;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] rk [16];

  always #5 clk = ~clk;

  aes_encrypt_iter_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .plaintext(plaintext),
    .ready(ready), .busy(busy), .key_idx(key_idx), .round_key(round_key),
    .round_in(round_in), .round_is_last(round_is_last), .round_out(round_out),
    .ciphertext(ciphertext), .done(done)
  );

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  // S-box = affine(x^254) in GF(2^8)
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, base, e;
    r = 8'h01; base = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] din, input logic [127:0] key,
                                             input logic last);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = sbox(din[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r + 4*c] = s[r + 4*((c + r) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ key;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
        tmp[31:24] = tmp[31:24] ^ rcon;
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++)
      rk[j] = (j <= NR) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : 128'h0;
  endtask

  // Combinational key store and round datapath
  assign round_key = rk[key_idx];
  assign round_out = aes_round(round_in, round_key, round_is_last);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one block from an IDLE cycle; returns at the cycle where done is high.
  task automatic run_block(input string name, input logic [127:0] pt, input logic [127:0] ct,
                           input bit hold, input bit chk_prev, input logic [127:0] prev,
                           input int inject);
    int           n;
    bit           seq_ok, hold_ok;
    logic [127:0] k0;
    check({name, "_ready_at_start"}, 128'(ready), 128'(1'b1));
    plaintext = pt;
    start     = 1'b1;
    k0        = rk[0];
    n         = 0;
    seq_ok    = 1'b1;
    hold_ok   = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (!hold && n == 1) start = 1'b0;
      if (inject != 0 && n == inject) begin
        start     = 1'b1;
        plaintext = '1;
      end
      if (inject != 0 && n == inject + 1) start = 1'b0;
      if (!done) begin
        if (busy !== 1'b1 || ready !== 1'b0 || key_idx !== 4'(n) ||
            round_is_last !== (n == NR)) seq_ok = 1'b0;
        if (n == 1 && round_in !== (pt ^ k0)) seq_ok = 1'b0;
        if (chk_prev && ciphertext !== prev) hold_ok = 1'b0;
      end
    end while (!done && n < 3 * NR);
    check({name, "_done_edges"}, 128'(n), 128'(NR + 1));
    check({name, "_done"}, 128'(done), 128'(1'b1));
    check({name, "_ct"}, ciphertext, ct);
    check({name, "_keyidx_last_busy_seq"}, 128'(seq_ok), 128'(1'b1));
    check({name, "_ready_at_done"}, 128'(ready), 128'(1'b1));
    if (chk_prev) check({name, "_prev_ct_hold"}, 128'(hold_ok), 128'(1'b1));
  endtask

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit saw_done;

    vecs[0] = '{"fips_b",  KEY_B,  PT_B,  CT_B};
    vecs[1] = '{"fips_c1", KEY_C1, PT_C1, CT_C1};
    vecs[2] = '{"zero",    128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    // Reset held 3 cycles with start high: nothing may begin.
    rst       = 1'b1;
    start     = 1'b1;
    plaintext = PT_B;
    expand(KEY_B);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_flags", 128'({ready, busy, done, key_idx, round_is_last}),
            128'({1'b1, 1'b0, 1'b0, 4'd0, 1'b0}));
      check("rst_ct", ciphertext, 128'h0);
      check("rst_round_in", round_in, 128'h0);
    end
    rst = 1'b0;
    // Start still high: accepted on the first edge after reset release, then held.
    run_block("post_rst", PT_B, CT_B, 1'b1, 1'b0, 128'h0, 0);
    run_block("held_start", PT_B, CT_B, 1'b1, 1'b1, CT_B, 0);
    start = 1'b0;
    @(posedge clk); #1;
    check("held_done_clears", 128'(done), 128'(1'b0));

    for (int i = 0; i < 3; i++) begin
      expand(vecs[i].key);
      run_block(vecs[i].name, vecs[i].pt, vecs[i].ct, 1'b0, 1'b0, 128'h0, 0);
      @(posedge clk); #1;
      check({vecs[i].name, "_done_pulse_1cyc"}, 128'(done), 128'(1'b0));
      check({vecs[i].name, "_ct_holds"}, ciphertext, vecs[i].ct);
    end

    // Back-to-back: second start lands in the done cycle of the first.
    expand(KEY_B);
    run_block("b2b_first", PT_B, CT_B, 1'b0, 1'b0, 128'h0, 0);
    expand(KEY_C1);
    run_block("b2b_second", PT_C1, CT_C1, 1'b0, 1'b1, CT_B, 0);
    @(posedge clk); #1;

    // Start with all-ones plaintext pulsed at round 5 must be ignored.
    run_block("start_in_run", PT_C1, CT_C1, 1'b0, 1'b1, CT_C1, 5);
    @(posedge clk); #1;
    check("start_in_run_no_restart", 128'(busy), 128'(1'b0));

    // Reset at round 4 aborts the block.
    expand(KEY_B);
    plaintext = PT_B;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midrst_at_round4", 128'(key_idx), 128'(4'd4));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_flags", 128'({ready, busy, done, key_idx}),
          128'({1'b1, 1'b0, 1'b0, 4'd0}));
    check("midrst_ct", ciphertext, 128'h0);
    saw_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", 128'(saw_done), 128'(1'b0));
    run_block("after_midrst", PT_B, CT_B, 1'b0, 1'b1, 128'h0, 0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_encrypt_iter_ctrl.md
# aes_encrypt_iter_ctrl

Sequential controller for AES-128 encryption that drives the combinational single-round datapath (`encryptRound_Iterative`-style round: SubBytes, ShiftRows, MixColumns bypassed on the last round, AddRoundKey). It accepts a plaintext block with a start/ready handshake and performs the initial AddRoundKey. It then iterates the round datapath once per clock, NR times, requesting round keys by index from an external key store. It presents the ciphertext with a one-cycle done pulse.

## Interface
Parameters:
- `NR`, 10, number of cipher rounds; the key index range is 0..NR.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to encrypt `plaintext`; accepted only when `ready`=1.
- `plaintext`  in  128  input block; sampled only on an accepted start.
- `ready`  out  1  high exactly when the FSM is in IDLE.
- `busy`  out  1  high exactly when the FSM is in RUN.
- `key_idx`  out  4  round-key index requested from the key store.
- `round_key`  in  128  key for `key_idx`; combinational, valid in the same cycle.
- `round_in`  out  128  state fed to the round datapath `in`.
- `round_is_last`  out  1  drives the round datapath `is_last_round`.
- `round_out`  in  128  round datapath `out`; combinational from `round_in`, `round_key`, `round_is_last`.
- `ciphertext`  out  128  registered result; holds its value until the next done.
- `done`  out  1  one-cycle pulse when `ciphertext` updates.

## Operation
FSM states: IDLE and RUN. Registers:
- `state_reg[127:0]`
- `rnd[3:0]`
- `ciphertext`
- `done`

IDLE:
- `key_idx`=0.
- `round_is_last`=0.
- `round_in`=`state_reg`.
- When `start`=1, on the clock edge: `state_reg` <= `plaintext` ^ `round_key` (key 0), `rnd` <= 1, go to RUN.

RUN:
- `key_idx`=`rnd`.
- `round_in`=`state_reg`.
- `round_is_last`=(`rnd`==NR).
- When `rnd` < NR, on the clock edge: `state_reg` <= `round_out`, `rnd` <= `rnd`+1.
- When `rnd`==NR, on the clock edge: `ciphertext` <= `round_out`, `done` <= 1, `state_reg` <= `round_out`, `rnd` <= 0, go to IDLE.

`done` is cleared on every edge where it is not being set.

Boundary conditions:
- `start` is ignored while in RUN. `plaintext` changes during RUN have no effect.
- `start` in the same cycle as `done`=1 is accepted, because the FSM is already in IDLE. Back-to-back blocks therefore run with no gap.
- `start` held high continuously produces back-to-back encryptions.
- `rst` asserted mid-operation aborts the operation. No done is produced and `ciphertext` clears to 0.
- `rnd` never exceeds NR. Any illegal state encoding returns to IDLE.
- All XORs are full 128-bit. No width truncation occurs anywhere.

## Timing
Reset values:
- `ready`=1, `busy`=0, `done`=0.
- `ciphertext`=0, `state_reg`=0, `rnd`=0.
- `key_idx`=0, `round_is_last`=0, `round_in`=0.

Latency, with the start accepted at edge E0:
- Round r is computed combinationally in the cycle after edge E(r-1) and registered at edge Er.
- `done`=1 and the valid `ciphertext` appear after edge E(NR), i.e. NR+1 edges after the accept cycle begins. For NR=10 this is 11 cycles.
- Throughput is one block per NR+1 cycles.
- `round_is_last`=1 for exactly one cycle per block, the cycle with `key_idx`=NR.
- The key store must produce the key for `key_idx` combinationally within the same cycle.

## Test plan
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, with the bench expanding the keys into its key-store model; pt 3243f6a8885a308d313198a2e0370734.
  - Required response: ct 3925841d02dc09fbdc118597196a0b32, `done` 11 cycles after the accepting edge, `key_idx` sequence 0,1,...,10.
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required response: ct 69c4e0d86a7b0430d8cdb78070b4c55a. `round_is_last` high only in the `key_idx`=10 cycle.
- Back-to-back:
  - Stimulus: B vector, then `start` with the C.1 pt asserted during the `done` cycle (key store switched to the C.1 key).
  - Required response: second `done` exactly 11 cycles later with the C.1 ct. The first ct holds until then.
- Start during RUN:
  - Stimulus: pulse `start` with pt FF..FF at round 5.
  - Required response: ignored, `busy` stays high, result still equals the original vector's ct.
- Reset mid-run:
  - Stimulus: assert `rst` at round 4 for 1 cycle.
  - Required response: next cycle `ready`=1, `done`=0, `ciphertext`=0, `key_idx`=0. No `done` pulse follows; a new start then completes correctly.
- Reset values:
  - Stimulus: `rst` held 3 cycles with `start`=1.
  - Required response: all outputs at their reset values and no operation begins. The start is accepted on the first cycle after `rst` deasserts.
